// File: rtl/fsm_seq_pkg.sv
// Shared types and default sizing for the parametrised sequence controller.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctl_state_e;

    localparam int DEF_NUM_STATES = 4;
    localparam int DEF_DWELL_W    = 8;
    localparam int DEF_WRAP_W     = 8;

endpackage

// File: rtl/fsm_seq_dwell_regs.sv
// Dwell table: one register per sequence index, single write port, combinational read.
module fsm_seq_dwell_regs
    import fsm_seq_pkg::*;
#(
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int STATE_W    = $clog2(NUM_STATES),
    parameter int DWELL_W    = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [STATE_W-1:0] wr_idx,
    input  logic [DWELL_W-1:0] wr_data,
    input  logic [STATE_W-1:0] rd_idx,
    output logic [DWELL_W-1:0] rd_data
);

    logic [DWELL_W-1:0] entry [NUM_STATES];

    // Only in-range indices have a matching decoder, so out-of-range writes fall through.
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_entry
        logic [DWELL_W-1:0] value_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                value_reg <= '0;
            end else if (wr_en && (wr_idx == STATE_W'(gi))) begin
                value_reg <= wr_data;
            end
        end

        assign entry[gi] = value_reg;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (rd_idx == STATE_W'(i)) begin
                rd_data = entry[i];
            end
        end
    end

endmodule

// File: rtl/fsm_sequencer.sv
// Steps an index 0..NUM_STATES-1 with a programmable dwell per index;
// start/hold/abort control, one-shot or continuous, step/done pulses and a wrap counter.
module fsm_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int STATE_W    = $clog2(NUM_STATES),
    parameter int DWELL_W    = DEF_DWELL_W,
    parameter int WRAP_W     = DEF_WRAP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hold,
    input  logic               abort,
    input  logic               mode_cont,
    input  logic               dwell_wr_en,
    input  logic [STATE_W-1:0] dwell_wr_idx,
    input  logic [DWELL_W-1:0] dwell_wr_data,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               step,
    output logic               done,
    output logic [WRAP_W-1:0]  wrap_cnt
);

    localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(NUM_STATES - 1);

    ctl_state_e         ctl_reg;
    logic [STATE_W-1:0] state_reg;
    logic [DWELL_W-1:0] cnt_reg;
    logic               busy_reg;
    logic               step_reg;
    logic               done_reg;
    logic [WRAP_W-1:0]  wrap_reg;

    logic [STATE_W-1:0] rd_idx;
    logic [DWELL_W-1:0] rd_data;

    fsm_seq_dwell_regs #(
        .NUM_STATES(NUM_STATES),
        .STATE_W   (STATE_W),
        .DWELL_W   (DWELL_W)
    ) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (dwell_wr_en),
        .wr_idx (dwell_wr_idx),
        .wr_data(dwell_wr_data),
        .rd_idx (rd_idx),
        .rd_data(rd_data)
    );

    // The only loads are dwell[0] (launch or wrap) and dwell[state+1] (advance),
    // so one read port pointed at the next index to be loaded is enough.
    always_comb begin
        rd_idx = '0;
        if ((ctl_reg != IDLE) && (state_reg != LAST_IDX)) begin
            rd_idx = state_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_reg   <= IDLE;
            state_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            step_reg  <= 1'b0;
            done_reg  <= 1'b0;
            wrap_reg  <= '0;
        end else begin
            step_reg <= 1'b0;
            done_reg <= 1'b0;
            case (ctl_reg)
                IDLE: begin
                    state_reg <= '0;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    if (start && !abort) begin
                        ctl_reg  <= RUN;
                        busy_reg <= 1'b1;
                        cnt_reg  <= rd_data;
                    end
                end
                RUN: begin
                    if (abort) begin
                        ctl_reg   <= IDLE;
                        state_reg <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (hold) begin
                        ctl_reg <= HOLD;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (state_reg != LAST_IDX) begin
                        state_reg <= state_reg + 1'b1;
                        step_reg  <= 1'b1;
                        cnt_reg   <= rd_data;
                    end else if (mode_cont) begin
                        state_reg <= '0;
                        step_reg  <= 1'b1;
                        wrap_reg  <= wrap_reg + 1'b1;
                        cnt_reg   <= rd_data;
                    end else begin
                        ctl_reg   <= IDLE;
                        state_reg <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        step_reg  <= 1'b1;
                    end
                end
                HOLD: begin
                    // Leaving HOLD costs one edge with the count untouched, so the
                    // remaining dwell is served in full once back in RUN.
                    if (abort) begin
                        ctl_reg   <= IDLE;
                        state_reg <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (!hold) begin
                        ctl_reg <= RUN;
                    end
                end
                default: begin
                    ctl_reg   <= IDLE;
                    state_reg <= '0;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign state    = state_reg;
    assign busy     = busy_reg;
    assign step     = step_reg;
    assign done     = done_reg;
    assign wrap_cnt = wrap_reg;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed bench for fsm_sequencer: one-shot, continuous, hold, abort, dwell writes and reset.
module tb_fsm_sequencer;

    // Index port is 3 bits wide so that idx=5 can be presented to a 4-index table.
    localparam int NS = 4;
    localparam int SW = 3;
    localparam int DW = 8;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          abort = 1'b0;
    logic          mode_cont = 1'b0;
    logic          dwell_wr_en = 1'b0;
    logic [SW-1:0] dwell_wr_idx = '0;
    logic [DW-1:0] dwell_wr_data = '0;
    logic [SW-1:0] state;
    logic          busy;
    logic          step;
    logic          done;
    logic [WW-1:0] wrap_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fsm_sequencer #(
        .NUM_STATES(NS),
        .STATE_W   (SW),
        .DWELL_W   (DW),
        .WRAP_W    (WW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hold         (hold),
        .abort        (abort),
        .mode_cont    (mode_cont),
        .dwell_wr_en  (dwell_wr_en),
        .dwell_wr_idx (dwell_wr_idx),
        .dwell_wr_data(dwell_wr_data),
        .state        (state),
        .busy         (busy),
        .step         (step),
        .done         (done),
        .wrap_cnt     (wrap_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int bsy, input int stp, input int dn);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".busy"},  32'(busy),  32'(bsy));
        check({tag, ".step"},  32'(step),  32'(stp));
        check({tag, ".done"},  32'(done),  32'(dn));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input int data);
        dwell_wr_en   = 1'b1;
        dwell_wr_idx  = SW'(idx);
        dwell_wr_data = DW'(data);
        tick();
        dwell_wr_en = 1'b0;
        $display("tb: dwell write idx=%0d data=%0d", idx, data);
    endtask

    initial begin : stim
        int seq [7];
        int occ [4];
        logic exp_step;

        seq = '{0, 0, 0, 1, 2, 2, 3};
        occ = '{3, 5, 2, 1};

        // Reset state
        #3;
        chk_all("rst", 0, 0, 0, 0);
        check("rst.wrap", 32'(wrap_cnt), 0);
        #9 reset = 1'b1;
        tick();
        $display("tb: reset released");

        // All dwell zero, one-shot
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("os0", 0, 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_all("os_adv", i, 1, 1, 0);
        end
        tick();
        chk_all("os_done", 0, 0, 1, 1);
        tick();
        chk_all("os_idle", 0, 0, 0, 0);
        $display("tb: one-shot zero-dwell sequence complete");

        // Dwell {2,0,1,0}, continuous, two wraps
        wr(0, 2);
        wr(2, 1);
        mode_cont = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            exp_step = (k > 0) && (seq[k % 7] != seq[(k + 6) % 7]);
            chk_all("cont", seq[k % 7], 1, int'(exp_step), 0);
            check("cont.wrap", 32'(wrap_cnt), 32'(k / 7));
        end
        tick();
        chk_all("cont_w2", 0, 1, 1, 0);
        check("cont_w2.wrap", 32'(wrap_cnt), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_all("cont_abort", 0, 0, 0, 0);
        check("cont_abort.wrap", 32'(wrap_cnt), 2);
        $display("tb: continuous two-wrap run aborted, wrap_cnt=%0d", wrap_cnt);

        // Hold for 5 edges at index 1, one cycle into dwell 3; table now {2,3,1,0}
        wr(1, 3);
        start = 1'b1;
        tick();
        start = 1'b1;               // start while busy must not restart
        tick();
        start = 1'b0;
        tick();
        chk_all("h_pre0", 0, 1, 0, 0);
        tick();
        chk_all("h_enter1", 1, 1, 1, 0);
        tick();
        chk_all("h_1cyc", 1, 1, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("h_frozen", 1, 1, 0, 0);
        end
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("h_resume", 1, 1, 0, 0);
        end
        tick();
        chk_all("h_adv2", 2, 1, 1, 0);
        $display("tb: hold at index 1 released, advanced to %0d", state);

        // Abort from HOLD, then start+abort together in IDLE
        hold = 1'b1;
        tick();
        chk_all("ab_hold", 2, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        hold  = 1'b0;
        chk_all("ab_idle", 0, 0, 0, 0);
        check("ab_idle.wrap", 32'(wrap_cnt), 2);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_all("ab_st", 0, 0, 0, 0);
        tick();
        chk_all("ab_st_after", 0, 0, 0, 0);
        $display("tb: abort from HOLD and start+abort in IDLE done");

        // Rewrite dwell[1]=4 while at index 1, plus an out-of-range write
        mode_cont = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_all("dw_pre", 0, 1, 0, 0);
        tick();
        chk_all("dw_at1", 1, 1, 1, 0);
        wr(1, 4);
        chk_all("dw_w1", 1, 1, 0, 0);
        wr(5, 9);
        chk_all("dw_w5", 1, 1, 0, 0);
        tick();
        chk_all("dw_old", 1, 1, 0, 0);
        tick();
        chk_all("dw_adv2", 2, 1, 1, 0);
        tick();
        chk_all("dw_2b", 2, 1, 0, 0);
        tick();
        chk_all("dw_adv3", 3, 1, 1, 0);
        tick();
        chk_all("dw_done", 0, 0, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int st = 0; st < 4; st++) begin
            for (int c = 0; c < occ[st]; c++) begin
                if (!(st == 0 && c == 0)) tick();
                chk_all("dw_new", st, 1, int'(c == 0 && st > 0), 0);
            end
        end
        tick();
        chk_all("dw_new_done", 0, 0, 1, 1);
        $display("tb: dwell rewrite visible on next visit only");

        // Asynchronous reset mid-RUN at index 2
        mode_cont = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && state != 3'd2; i++) tick();
        check("ar.reach2", 32'(state), 2);
        check("ar.wrap_pre", 32'(wrap_cnt), 2);
        #1 reset = 1'b0;
        #2;
        chk_all("ar", 0, 0, 0, 0);
        check("ar.wrap", 32'(wrap_cnt), 0);
        #3 reset = 1'b1;
        tick();
        mode_cont = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ar_seq0", 0, 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_all("ar_seq", i, 1, 1, 0);
        end
        tick();
        chk_all("ar_done", 0, 0, 1, 1);
        $display("tb: async reset cleared state, wrap count and dwell table");

        // Wrap counter rolls over modulo 2^WRAP_W
        mode_cont = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4 * 255) tick();
        chk_all("wm_255", 0, 1, 1, 0);
        check("wm_255.wrap", 32'(wrap_cnt), 255);
        repeat (4) tick();
        chk_all("wm_256", 0, 1, 1, 0);
        check("wm_256.wrap", 32'(wrap_cnt), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("tb: wrap counter rollover, wrap_cnt=%0d", wrap_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_sequencer.md
Name: fsm_sequencer

Overview:
Parametrised successor to the team's 4-state cycling controller. Steps a sequence index through NUM_STATES states, 0 to NUM_STATES-1. Each index holds for a programmable dwell time. Adds start, hold and abort control, one-shot or continuous mode, a per-step strobe, a done pulse and a wrap counter. Sits under the top-level control logic and drives downstream phase/stage selects.

Parameters:
NUM_STATES, 4, number of sequence indices (>=2)
STATE_W, $clog2(NUM_STATES), width of the index output
DWELL_W, 8, width of each dwell entry
WRAP_W, 8, width of the wrap counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a sequence; honoured only in IDLE
hold  in  1  freeze the sequence while high
abort  in  1  terminate immediately, return to IDLE
mode_cont  in  1  1 = wrap continuously, 0 = one-shot
dwell_wr_en  in  1  dwell table write strobe
dwell_wr_idx  in  STATE_W  dwell entry to write
dwell_wr_data  in  DWELL_W  dwell value; index occupies value+1 cycles
state  out  STATE_W  current sequence index, registered
busy  out  1  high in RUN or HOLD
step  out  1  one-cycle pulse on the cycle the index changes
done  out  1  one-cycle pulse when a one-shot sequence completes
wrap_cnt  out  WRAP_W  count of completed wraps in continuous mode, modulo 2^WRAP_W

Behaviour:
- Reset is asynchronous, active-low. It sets: control = IDLE, state=0, busy=0, step=0, done=0, wrap_cnt=0, dwell counter=0, all dwell entries=0.
- Control FSM has three states: IDLE, RUN, HOLD. All outputs are registered.
- IDLE: state=0, busy=0.
  - start=1 at edge T: after T, control=RUN, busy=1, state=0, dwell counter loaded with dwell[0].
  - start=1 while busy is ignored; no restart.
- RUN, evaluated each edge in priority order abort > hold > advance:
  - abort=1: next cycle control=IDLE, state=0, busy=0, counter cleared. No done, no step, wrap_cnt unchanged.
  - hold=1: control=HOLD, counter and state frozen.
  - counter!=0: decrement.
  - counter==0 and state<NUM_STATES-1: state+1, step=1, counter loaded with dwell[state+1].
  - counter==0 and state==NUM_STATES-1, mode_cont=1: state=0, step=1, wrap_cnt+1 (wraps at 2^WRAP_W), counter loaded with dwell[0].
  - counter==0 and state==NUM_STATES-1, mode_cont=0: control=IDLE, state=0, busy=0, done=1, step=1.
  - mode_cont is sampled only at last-index expiry.
- HOLD:
  - abort=1: goes to IDLE exactly as from RUN.
  - hold=0: returns to RUN with counter and state unchanged; the remaining dwell is preserved.
  - busy stays 1; step=0.
- Dwell table:
  - Writable in any control state.
  - Takes effect at the next load of that entry; the active count is not altered.
  - dwell_wr_idx>=NUM_STATES: write ignored.
  - dwell=0 means a 1-cycle occupancy; with all entries 0 the index advances every cycle.
- Simultaneous start and abort in IDLE: abort wins and control stays IDLE.
- done and step are never high for more than one consecutive cycle, except: step stays high on every advancing cycle when dwell=0.

Decomposition:
- Package fsm_seq_pkg holds the ctl_state_e enum (IDLE, RUN, HOLD) and default parameter constants.
- One sub-module, fsm_seq_dwell_regs: NUM_STATES x DWELL_W register file. It has a write port and a combinational read at a given index, and is reset to 0.

Test Plan:
1. Reset low mid-RUN at state=2 -> state=0, busy=0, wrap_cnt=0 and all dwell entries 0 without waiting for a clock edge.
2. Dwell table all 0, mode_cont=0, start pulse -> state goes 0,1,2,3 on consecutive cycles; step high for 3 cycles, then on the expiry edge done=1 and step=1 for one cycle; state=0, busy=0.
3. dwell = {2,0,1,0}, mode_cont=1, run 2 full wraps -> state occupancies of 3,1,2,1 cycles; wrap_cnt=2; busy stays 1.
4. hold asserted for 5 cycles at state=1, 1 cycle into dwell 3 -> state frozen for 5 cycles; after release, 3 more cycles at state=1 before advancing.
5. abort during HOLD and abort together with start in IDLE -> IDLE next cycle, done=0, wrap_cnt unchanged; start in IDLE does not launch.
6. Write dwell[1]=4 while at index 1, and write idx=5 with NUM_STATES=4 -> current count unaffected; new value used on the next visit; the out-of-range write changes no entry.
